amm_rw_arbiter: RTL and testbench
=================================

Name: amm_rw_arbiter

Overview:
- Shares one Avalon-MM memory port between a read-only requester and a write-only requester.
- The read requester is the word fetcher in the byte_inc flow. The write requester is the write-back path.
- Arbitration is round-robin, one command at a time.
- The block tracks outstanding reads so that the number of in-flight read responses never exceeds MAX_PENDING.

Parameters:
- DATA_WIDTH, 64, data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, word address width.
- BYTE_CNT, DATA_WIDTH/8, byteenable width.
- MAX_PENDING, 4, maximum number of reads accepted by the slave but not yet returned; must be ≥1.

Ports:
- clk  in  1  clock.
- srst  in  1  synchronous reset, active-high.
- rd_address_i  in  ADDR_WIDTH  read requester address.
- rd_read_i  in  1  read request.
- rd_waitrequest_o  out  1  low exactly in the cycle the read is accepted.
- rd_readdata_o  out  DATA_WIDTH  returned read data.
- rd_datavalid_o  out  1  read data valid.
- wr_address_i  in  ADDR_WIDTH  write requester address.
- wr_write_i  in  1  write request.
- wr_writedata_i  in  DATA_WIDTH  write data.
- wr_byteenable_i  in  BYTE_CNT  write byte enables.
- wr_waitrequest_o  out  1  low exactly in the cycle the write is accepted.
- m_address_o  out  ADDR_WIDTH  slave address.
- m_read_o  out  1  slave read.
- m_write_o  out  1  slave write.
- m_writedata_o  out  DATA_WIDTH  slave write data.
- m_byteenable_o  out  BYTE_CNT  slave byte enables.
- m_waitrequest_i  in  1  slave stall.
- m_readdata_i  in  DATA_WIDTH  slave read data.
- m_datavalid_i  in  1  slave read data valid.
- pend_cnt_o  out  $clog2(MAX_PENDING+1)  current count of outstanding reads.

Behaviour:
- Clock and reset: one clock, clk. Reset srst is synchronous, active-high.
- FSM states:
  - IDLE: no command in progress.
  - RD_GNT: the read requester owns the slave port.
  - WR_GNT: the write requester owns the slave port.
- Read eligibility: rd_eligible = rd_read_i && (pend_cnt < MAX_PENDING).
- IDLE transitions:
  - Only rd_eligible → RD_GNT.
  - Only wr_write_i → WR_GNT.
  - Both → the side that is not last_grant (round-robin).
  - Neither → stay in IDLE.
- RD_GNT / WR_GNT outputs:
  - The owner's address, data and byteenable are driven combinationally onto m_*.
  - m_read_o = rd_read_i only in RD_GNT; m_write_o = wr_write_i only in WR_GNT.
- Command acceptance:
  - Accept = granted request high && !m_waitrequest_i.
  - On accept: the owner's waitrequest_o goes low for that cycle, last_grant is updated, and the FSM returns to IDLE.
  - Result: one arbitration bubble; peak throughput is 1 command per 2 cycles.
- Other waitrequest cases: waitrequest_o stays high in all other cycles, including for the non-owner and in IDLE.
- Withdrawn request: if the owner drops its request while granted (protocol violation), return to IDLE. No command is issued and last_grant is unchanged.
- Idle port: when not granted, m_read_o = m_write_o = 0. m_address_o, m_writedata_o and m_byteenable_o = 0.
- Read responses:
  - rd_readdata_o = m_readdata_i and rd_datavalid_o = m_datavalid_i, as a combinational pass-through.
  - Responses arrive in order; no response buffering is done.
- pend_cnt update rules:
  - +1 on read accept.
  - −1 on m_datavalid_i.
  - Both in the same cycle → unchanged.
  - m_datavalid_i with pend_cnt = 0 → no underflow; data is still forwarded.
- Full outstanding window: with pend_cnt = MAX_PENDING, a read is not granted. Writes continue to be granted.
- Grant commitment: a grant is never revoked while the slave stalls. m_waitrequest_i held high keeps the FSM in RD_GNT/WR_GNT indefinitely.
- Reset values: state = IDLE, last_grant = WR (so a read wins the first tie), pend_cnt = 0. All m_* command outputs = 0; both waitrequest_o = 1.
- Reset mid-operation: an in-flight command is abandoned and pend_cnt is cleared. Responses arriving after reset are still forwarded but not counted.

Optional Feature:
- Macro: AMM_ARB_WR_PRIORITY_EN.
- Defined: fixed priority. In IDLE, wr_write_i always wins over rd_eligible. last_grant is unused.
- Undefined: round-robin as above.

Test Plan:
- Single read to address 0x010, slave waitrequest low → m_read_o high in cycle 2 with address 0x010; rd_waitrequest_o low in cycle 2; pend_cnt 0→1. datavalid with 0xDEAD_BEEF_0000_0001 → forwarded, pend_cnt → 0.
- Read and write requested in the same cycle from reset → read is granted first, then the write. With both held, grants alternate R,W,R,W over 8 commands.
- Slave waitrequest high for 5 cycles during a write (byteenable 0x0F) → m_write_o, address, data and byteenable are stable all 5 cycles; accepted on cycle 6; a read arriving meanwhile waits.
- MAX_PENDING=4: issue 4 reads with no responses, then request a 5th → not granted; a write in this window is granted. One datavalid → the 5th read is granted. Same-cycle accept + datavalid → pend_cnt unchanged.
- Assert srst while in WR_GNT with pend_cnt = 3 → next cycle: IDLE, pend_cnt 0, waitrequests high, m_write_o 0.
- With AMM_ARB_WR_PRIORITY_EN defined, both requesters held continuously → only writes are granted until wr_write_i drops.

Source files
------------

// File: rtl/amm_rw_arbiter_if.sv
// rtl/amm_rw_arbiter_if.sv - requester and slave-side signal bundle for amm_rw_arbiter
interface amm_rw_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_CNT   = DATA_WIDTH / 8
);
    // read requester (word fetcher)
    logic [ADDR_WIDTH-1:0] rd_address_i;
    logic                  rd_read_i;
    logic                  rd_waitrequest_o;
    logic [DATA_WIDTH-1:0] rd_readdata_o;
    logic                  rd_datavalid_o;

    // write requester (write-back path)
    logic [ADDR_WIDTH-1:0] wr_address_i;
    logic                  wr_write_i;
    logic [DATA_WIDTH-1:0] wr_writedata_i;
    logic [BYTE_CNT-1:0]   wr_byteenable_i;
    logic                  wr_waitrequest_o;

    // shared memory port
    logic [ADDR_WIDTH-1:0] m_address_o;
    logic                  m_read_o;
    logic                  m_write_o;
    logic [DATA_WIDTH-1:0] m_writedata_o;
    logic [BYTE_CNT-1:0]   m_byteenable_o;
    logic                  m_waitrequest_i;
    logic [DATA_WIDTH-1:0] m_readdata_i;
    logic                  m_datavalid_i;

    // arbiter view
    modport master (
        input  rd_address_i, rd_read_i,
        output rd_waitrequest_o, rd_readdata_o, rd_datavalid_o,
        input  wr_address_i, wr_write_i, wr_writedata_i, wr_byteenable_i,
        output wr_waitrequest_o,
        output m_address_o, m_read_o, m_write_o, m_writedata_o, m_byteenable_o,
        input  m_waitrequest_i, m_readdata_i, m_datavalid_i
    );

    // environment view: requesters plus memory slave
    modport slave (
        output rd_address_i, rd_read_i,
        input  rd_waitrequest_o, rd_readdata_o, rd_datavalid_o,
        output wr_address_i, wr_write_i, wr_writedata_i, wr_byteenable_i,
        input  wr_waitrequest_o,
        input  m_address_o, m_read_o, m_write_o, m_writedata_o, m_byteenable_o,
        output m_waitrequest_i, m_readdata_i, m_datavalid_i
    );
endinterface

// File: rtl/amm_rw_arbiter.sv
// rtl/amm_rw_arbiter.sv - read/write Avalon-MM port arbiter with outstanding-read limit; AMM_ARB_WR_PRIORITY_EN selects fixed write priority
module amm_rw_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 10,
    parameter int BYTE_CNT    = DATA_WIDTH / 8,
    parameter int MAX_PENDING = 4,
    localparam int PCW        = $clog2(MAX_PENDING + 1)
) (
    input  logic               clk,
    input  logic               srst,
    amm_rw_arbiter_if.master   bus,
    output logic [PCW-1:0]     pend_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_GNT = 2'd1,
        ST_WR_GNT = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [PCW-1:0] pend_cnt_q, pend_cnt_d;
    logic           rd_eligible;
    logic           rd_accept;
    logic           wr_accept;
    logic           pend_dec;

`ifndef AMM_ARB_WR_PRIORITY_EN
    // 1 when the most recent accepted command was a write
    logic           last_grant_wr_q, last_grant_wr_d;
`endif

    // a read may only be granted while the response window has room
    assign rd_eligible = bus.rd_read_i && (pend_cnt_q < PCW'(MAX_PENDING));

    // a command is accepted when the owner still requests and the slave does not stall
    assign rd_accept = (state_q == ST_RD_GNT) && bus.rd_read_i  && !bus.m_waitrequest_i;
    assign wr_accept = (state_q == ST_WR_GNT) && bus.wr_write_i && !bus.m_waitrequest_i;

    // responses with nothing outstanding (e.g. after reset) are forwarded but not counted
    assign pend_dec = bus.m_datavalid_i && (pend_cnt_q != '0);

    // state register
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: arbitrate in IDLE, hold the grant until accepted or withdrawn
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
`ifdef AMM_ARB_WR_PRIORITY_EN
                if (bus.wr_write_i) begin
                    state_d = ST_WR_GNT;
                end else if (rd_eligible) begin
                    state_d = ST_RD_GNT;
                end
`else
                if (rd_eligible && bus.wr_write_i) begin
                    state_d = last_grant_wr_q ? ST_RD_GNT : ST_WR_GNT;
                end else if (rd_eligible) begin
                    state_d = ST_RD_GNT;
                end else if (bus.wr_write_i) begin
                    state_d = ST_WR_GNT;
                end
`endif
            end
            ST_RD_GNT: begin
                // withdrawn request or accepted command both end the grant
                if (!bus.rd_read_i || !bus.m_waitrequest_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_GNT: begin
                if (!bus.wr_write_i || !bus.m_waitrequest_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // outputs: drive the owner's command onto the slave port, zeros otherwise
    always_comb begin
        bus.m_address_o      = {ADDR_WIDTH{1'b0}};
        bus.m_read_o         = 1'b0;
        bus.m_write_o        = 1'b0;
        bus.m_writedata_o    = {DATA_WIDTH{1'b0}};
        bus.m_byteenable_o   = {BYTE_CNT{1'b0}};
        bus.rd_waitrequest_o = 1'b1;
        bus.wr_waitrequest_o = 1'b1;
        case (state_q)
            ST_RD_GNT: begin
                bus.m_address_o      = bus.rd_address_i;
                bus.m_read_o         = bus.rd_read_i;
                bus.rd_waitrequest_o = !rd_accept;
            end
            ST_WR_GNT: begin
                bus.m_address_o      = bus.wr_address_i;
                bus.m_write_o        = bus.wr_write_i;
                bus.m_writedata_o    = bus.wr_writedata_i;
                bus.m_byteenable_o   = bus.wr_byteenable_i;
                bus.wr_waitrequest_o = !wr_accept;
            end
            default: begin
            end
        endcase
    end

`ifndef AMM_ARB_WR_PRIORITY_EN
    // round-robin memory: remember which side was served last
    always_comb begin
        last_grant_wr_d = last_grant_wr_q;
        if (rd_accept) begin
            last_grant_wr_d = 1'b0;
        end else if (wr_accept) begin
            last_grant_wr_d = 1'b1;
        end
    end

    // last-grant register; resets to write so a read wins the first tie
    always_ff @(posedge clk) begin
        if (srst) begin
            last_grant_wr_q <= 1'b1;
        end else begin
            last_grant_wr_q <= last_grant_wr_d;
        end
    end
`endif

    // outstanding-read count: accept adds one, a counted response removes one
    always_comb begin
        pend_cnt_d = pend_cnt_q;
        case ({rd_accept, pend_dec})
            2'b10:   pend_cnt_d = pend_cnt_q + PCW'(1);
            2'b01:   pend_cnt_d = pend_cnt_q - PCW'(1);
            default: pend_cnt_d = pend_cnt_q;
        endcase
    end

    // outstanding-read register
    always_ff @(posedge clk) begin
        if (srst) begin
            pend_cnt_q <= '0;
        end else begin
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt_o = pend_cnt_q;

    // responses are in order and unbuffered
    assign bus.rd_readdata_o  = bus.m_readdata_i;
    assign bus.rd_datavalid_o = bus.m_datavalid_i;

endmodule

// File: tb/tb_amm_rw_arbiter.sv
// tb/tb_amm_rw_arbiter.sv - directed and randomized checks for amm_rw_arbiter
module tb_amm_rw_arbiter;

    localparam int DW  = 64;
    localparam int AW  = 10;
    localparam int BC  = DW / 8;
    localparam int MXP = 4;
    localparam int PCW = $clog2(MXP + 1);

    logic           clk;
    logic           srst;
    logic [PCW-1:0] pend_cnt_o;

    int total;
    int bad;

    amm_rw_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_CNT(BC)) bus ();

    amm_rw_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BYTE_CNT   (BC),
        .MAX_PENDING(MXP)
    ) dut (
        .clk       (clk),
        .srst      (srst),
        .bus       (bus),
        .pend_cnt_o(pend_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.rd_address_i    = '0;
        bus.rd_read_i       = 1'b0;
        bus.wr_address_i    = '0;
        bus.wr_write_i      = 1'b0;
        bus.wr_writedata_i  = '0;
        bus.wr_byteenable_i = '0;
        bus.m_waitrequest_i = 1'b0;
        bus.m_readdata_i    = '0;
        bus.m_datavalid_i   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        srst = 1'b1;
        tick();
        tick();
        srst = 1'b0;
    endtask

    // reference model state for the randomized phase
    int          m_pend;
    bit          m_last_wr;
    int          m_owner;   // 0 none, 1 read, 2 write
    bit          rq_rd, rq_wr;
    logic [63:0] resp_q[$];

    initial begin
        byte         got[$];
        byte         expg;
        logic [63:0] dv_data;
        logic [63:0] exp_addr, exp_wd, exp_be;
        bit          mw, dv, rd_acc, wr_acc, elig;
        int          old_pend;

        total = 0;
        bad   = 0;
        srst  = 1'b1;
        clear_inputs();

        // ---- reset state
        tick();
        sample();
        chk("rst_rd_wait", bus.rd_waitrequest_o, 1);
        chk("rst_wr_wait", bus.wr_waitrequest_o, 1);
        chk("rst_m_read", bus.m_read_o, 0);
        chk("rst_m_write", bus.m_write_o, 0);
        chk("rst_m_addr", bus.m_address_o, 0);
        chk("rst_pend", pend_cnt_o, 0);
        tick();
        srst = 1'b0;

        // ---- single read to 0x010
        bus.rd_read_i = 1'b1;
        bus.rd_address_i = 10'h010;
        sample();
        chk("t1_c1_m_read", bus.m_read_o, 0);
        chk("t1_c1_rd_wait", bus.rd_waitrequest_o, 1);
        tick();
        sample();
        chk("t1_c2_m_read", bus.m_read_o, 1);
        chk("t1_c2_addr", bus.m_address_o, 10'h010);
        chk("t1_c2_rd_wait", bus.rd_waitrequest_o, 0);
        chk("t1_c2_pend", pend_cnt_o, 0);
        tick();
        bus.rd_read_i = 1'b0;
        bus.m_datavalid_i = 1'b1;
        bus.m_readdata_i = 64'hDEAD_BEEF_0000_0001;
        sample();
        chk("t1_pend_one", pend_cnt_o, 1);
        chk("t1_dv_fwd", bus.rd_datavalid_o, 1);
        chk("t1_data_fwd", bus.rd_readdata_o, 64'hDEAD_BEEF_0000_0001);
        tick();
        bus.m_datavalid_i = 1'b0;
        sample();
        chk("t1_pend_zero", pend_cnt_o, 0);
        tick();

        // ---- simultaneous requests from reset, held for 8 commands
        do_reset();
        bus.rd_read_i = 1'b1;
        bus.rd_address_i = 10'h100;
        bus.wr_write_i = 1'b1;
        bus.wr_address_i = 10'h200;
        bus.wr_writedata_i = 64'h0123_4567_89AB_CDEF;
        bus.wr_byteenable_i = 8'hFF;
        for (int c = 0; c < 16; c++) begin
            sample();
            if (!bus.rd_waitrequest_o) got.push_back("R");
            else if (!bus.wr_waitrequest_o) got.push_back("W");
            tick();
        end
        clear_inputs();
        chk("t2_grant_count", got.size(), 8);
        for (int k = 0; k < 8 && k < got.size(); k++) begin
`ifdef AMM_ARB_WR_PRIORITY_EN
            expg = "W";
`else
            expg = (k % 2 == 0) ? "R" : "W";
`endif
            chk($sformatf("t2_grant_%0d", k), got[k], expg);
        end

        // ---- write stalled for 5 cycles, read arrives meanwhile
        do_reset();
        bus.wr_write_i = 1'b1;
        bus.wr_address_i = 10'h02A;
        bus.wr_writedata_i = 64'h1122_3344_5566_7788;
        bus.wr_byteenable_i = 8'h0F;
        bus.m_waitrequest_i = 1'b1;
        sample();
        chk("t3_idle_m_write", bus.m_write_o, 0);
        tick();
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                bus.rd_read_i = 1'b1;
                bus.rd_address_i = 10'h033;
            end
            sample();
            chk($sformatf("t3_stall%0d_m_write", c), bus.m_write_o, 1);
            chk($sformatf("t3_stall%0d_addr", c), bus.m_address_o, 10'h02A);
            chk($sformatf("t3_stall%0d_data", c), bus.m_writedata_o, 64'h1122_3344_5566_7788);
            chk($sformatf("t3_stall%0d_be", c), bus.m_byteenable_o, 8'h0F);
            chk($sformatf("t3_stall%0d_wr_wait", c), bus.wr_waitrequest_o, 1);
            chk($sformatf("t3_stall%0d_m_read", c), bus.m_read_o, 0);
            chk($sformatf("t3_stall%0d_rd_wait", c), bus.rd_waitrequest_o, 1);
            tick();
        end
        bus.m_waitrequest_i = 1'b0;
        sample();
        chk("t3_accept_wr_wait", bus.wr_waitrequest_o, 0);
        chk("t3_accept_m_write", bus.m_write_o, 1);
        tick();
        bus.wr_write_i = 1'b0;
        sample();
        chk("t3_bubble_m_read", bus.m_read_o, 0);
        tick();
        sample();
        chk("t3_rd_m_read", bus.m_read_o, 1);
        chk("t3_rd_addr", bus.m_address_o, 10'h033);
        chk("t3_rd_wait", bus.rd_waitrequest_o, 0);
        tick();
        clear_inputs();

        // ---- full outstanding window
        do_reset();
        bus.rd_read_i = 1'b1;
        bus.rd_address_i = 10'h155;
        for (int c = 0; c < 8; c++) tick();
        for (int c = 0; c < 3; c++) begin
            sample();
            chk($sformatf("t4_full%0d_pend", c), pend_cnt_o, MXP);
            chk($sformatf("t4_full%0d_m_read", c), bus.m_read_o, 0);
            chk($sformatf("t4_full%0d_rd_wait", c), bus.rd_waitrequest_o, 1);
            tick();
        end
        bus.wr_write_i = 1'b1;
        bus.wr_address_i = 10'h3FF;
        bus.wr_byteenable_i = 8'hA5;
        tick();
        sample();
        chk("t4_wr_granted", bus.m_write_o, 1);
        chk("t4_wr_accept", bus.wr_waitrequest_o, 0);
        tick();
        bus.wr_write_i = 1'b0;
        bus.m_datavalid_i = 1'b1;
        bus.m_readdata_i = 64'h5A5A_0000_1111_2222;
        sample();
        chk("t4_dv_m_read", bus.m_read_o, 0);
        tick();
        bus.m_datavalid_i = 1'b0;
        sample();
        chk("t4_pend_after_dv", pend_cnt_o, MXP - 1);
        chk("t4_arb_m_read", bus.m_read_o, 0);
        tick();
        bus.m_datavalid_i = 1'b1;
        sample();
        chk("t4_fifth_m_read", bus.m_read_o, 1);
        chk("t4_fifth_rd_wait", bus.rd_waitrequest_o, 0);
        tick();
        bus.m_datavalid_i = 1'b0;
        bus.rd_read_i = 1'b0;
        sample();
        chk("t4_same_cycle_pend", pend_cnt_o, MXP - 1);
        tick();

        // ---- reset while a write is granted with 3 reads outstanding
        bus.wr_write_i = 1'b1;
        bus.wr_address_i = 10'h0AA;
        bus.m_waitrequest_i = 1'b1;
        tick();
        srst = 1'b1;
        sample();
        chk("t5_pre_m_write", bus.m_write_o, 1);
        chk("t5_pre_pend", pend_cnt_o, 3);
        tick();
        srst = 1'b0;
        bus.wr_write_i = 1'b0;
        bus.m_waitrequest_i = 1'b0;
        bus.m_datavalid_i = 1'b1;
        bus.m_readdata_i = 64'hCAFE_F00D_0000_0042;
        sample();
        chk("t5_m_write", bus.m_write_o, 0);
        chk("t5_wr_wait", bus.wr_waitrequest_o, 1);
        chk("t5_rd_wait", bus.rd_waitrequest_o, 1);
        chk("t5_pend", pend_cnt_o, 0);
        chk("t5_late_dv", bus.rd_datavalid_o, 1);
        chk("t5_late_data", bus.rd_readdata_o, 64'hCAFE_F00D_0000_0042);
        tick();
        bus.m_datavalid_i = 1'b0;
        sample();
        chk("t5_no_underflow", pend_cnt_o, 0);
        tick();

        // ---- randomized traffic against a transaction-level model
        do_reset();
        m_pend = 0;
        m_last_wr = 1'b1;
        m_owner = 0;
        rq_rd = 1'b0;
        rq_wr = 1'b0;
        resp_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!rq_rd && $urandom_range(0, 99) < 45) begin
                rq_rd = 1'b1;
                bus.rd_address_i = AW'($urandom);
            end
            if (!rq_wr && $urandom_range(0, 99) < 45) begin
                rq_wr = 1'b1;
                bus.wr_address_i = AW'($urandom);
                bus.wr_writedata_i = {$urandom, $urandom};
                bus.wr_byteenable_i = BC'($urandom);
            end
            bus.rd_read_i = rq_rd;
            bus.wr_write_i = rq_wr;
            mw = ($urandom_range(0, 99) < 30);
            bus.m_waitrequest_i = mw;
            dv = 1'b0;
            dv_data = {$urandom, $urandom};
            if (resp_q.size() > 0 && $urandom_range(0, 99) < 35) begin
                dv = 1'b1;
                dv_data = resp_q.pop_front();
            end else if (resp_q.size() == 0 && $urandom_range(0, 99) < 3) begin
                dv = 1'b1;
            end
            bus.m_datavalid_i = dv;
            bus.m_readdata_i = dv_data;

            rd_acc = (m_owner == 1) && !mw;
            wr_acc = (m_owner == 2) && !mw;
            exp_addr = (m_owner == 1) ? 64'(bus.rd_address_i) : (m_owner == 2) ? 64'(bus.wr_address_i) : 64'd0;
            exp_wd = (m_owner == 2) ? bus.wr_writedata_i : 64'd0;
            exp_be = (m_owner == 2) ? 64'(bus.wr_byteenable_i) : 64'd0;

            sample();
            chk($sformatf("rnd%0d_m_read", cyc), bus.m_read_o, (m_owner == 1));
            chk($sformatf("rnd%0d_m_write", cyc), bus.m_write_o, (m_owner == 2));
            chk($sformatf("rnd%0d_addr", cyc), bus.m_address_o, exp_addr);
            chk($sformatf("rnd%0d_wdata", cyc), bus.m_writedata_o, exp_wd);
            chk($sformatf("rnd%0d_be", cyc), bus.m_byteenable_o, exp_be);
            chk($sformatf("rnd%0d_rd_wait", cyc), bus.rd_waitrequest_o, !rd_acc);
            chk($sformatf("rnd%0d_wr_wait", cyc), bus.wr_waitrequest_o, !wr_acc);
            chk($sformatf("rnd%0d_pend", cyc), pend_cnt_o, m_pend);
            chk($sformatf("rnd%0d_dv", cyc), bus.rd_datavalid_o, dv);
            if (dv) chk($sformatf("rnd%0d_rdata", cyc), bus.rd_readdata_o, dv_data);

            old_pend = m_pend;
            elig = rq_rd && (old_pend < MXP);
            if (m_owner == 0) begin
`ifdef AMM_ARB_WR_PRIORITY_EN
                if (rq_wr) m_owner = 2;
                else if (elig) m_owner = 1;
`else
                if (elig && rq_wr) m_owner = m_last_wr ? 1 : 2;
                else if (elig) m_owner = 1;
                else if (rq_wr) m_owner = 2;
`endif
            end else if (rd_acc) begin
                m_owner = 0;
                m_last_wr = 1'b0;
                rq_rd = 1'b0;
                resp_q.push_back({$urandom, $urandom});
            end else if (wr_acc) begin
                m_owner = 0;
                m_last_wr = 1'b1;
                rq_wr = 1'b0;
            end
            if (rd_acc) m_pend = m_pend + 1;
            if (dv && old_pend > 0) m_pend = m_pend - 1;
            tick();
        end
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
